// File: rtl/fb_pixel_reader_if.sv
// fb_pixel_reader_if: AXI read channels plus pixel stream and error flag of the framebuffer reader
interface fb_pixel_reader_if #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int PIXEL_BITS     = 12
);
  logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
  logic                      axi_arvalid;
  logic                      axi_arready;
  logic [AXI_DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]                axi_rresp;
  logic                      axi_rvalid;
  logic                      axi_rready;
  logic [PIXEL_BITS-1:0]     pixel_data;
  logic                      pixel_valid;
  logic                      pixel_ready;
  logic                      pixel_sof;
  logic                      pixel_eol;
  logic                      read_error;
  modport master (
    output axi_araddr, axi_arvalid, axi_rready, pixel_data, pixel_valid, pixel_sof, pixel_eol, read_error,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid, pixel_ready
  );
  modport slave (
    input  axi_araddr, axi_arvalid, axi_rready, pixel_data, pixel_valid, pixel_sof, pixel_eol, read_error,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid, pixel_ready
  );
endinterface

// File: rtl/fb_pixel_reader.sv
// fb_pixel_reader: credit-limited raster fetch of a framebuffer over AXI read, streamed out as pixels
module fb_pixel_reader #(
  parameter int H_VISIBLE       = 640,
  parameter int V_VISIBLE       = 480,
  parameter int PIXEL_BITS      = 12,
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  fb_pixel_reader_if.master   bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int XW = $clog2(H_VISIBLE + 1);
  localparam int YW = $clog2(V_VISIBLE + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST = AXI_ADDR_WIDTH'(H_VISIBLE * V_VISIBLE - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW:0]               cnt_q, cnt_d, wr_q, rd_q;
  logic [XW-1:0]             x_q;
  logic [YW-1:0]             y_q;
  logic [PIXEL_BITS-1:0]     mem_q [MAX_OUTSTANDING];
  logic                      err_q, ar_hs, r_push, p_hs, empty, eol;
  logic                      unused_ok;
  assign empty     = wr_q == rd_q;
  assign ar_hs     = bus.axi_arvalid && bus.axi_arready;
  assign r_push    = bus.axi_rvalid && bus.axi_rready;
  assign p_hs      = bus.pixel_valid && bus.pixel_ready;
  assign eol       = x_q == XW'(H_VISIBLE - 1);
  assign unused_ok = &{1'b0, bus.axi_rdata};
  // A credit is held from AR handshake until its pixel leaves, so the FIFO can never overflow
  assign cnt_d = cnt_q + {{PW{1'b0}}, ar_hs} - {{PW{1'b0}}, p_hs};
  assign bus.axi_arvalid = state_q == FETCH && cnt_q < (PW+1)'(MAX_OUTSTANDING);
  assign bus.axi_araddr  = addr_q;
  assign bus.axi_rready  = state_q != IDLE;
  assign bus.pixel_valid = !empty;
  assign bus.pixel_data  = empty ? '0 : mem_q[rd_q[PW-1:0]];
  assign bus.pixel_sof   = !empty && x_q == '0 && y_q == '0;
  assign bus.pixel_eol   = !empty && eol;
  assign bus.read_error  = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: if (enable) begin
        state_d = FETCH;
        addr_d  = '0;
      end
      FETCH: if (ar_hs) begin
        state_d = addr_q == LAST ? DRAIN : FETCH;
        addr_d  = addr_q == LAST ? '0 : addr_q + 1'b1;
      end
      DRAIN: if (cnt_q == '0) begin
        state_d = enable ? FETCH : IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      if (r_push) wr_q <= wr_q + 1'b1;
      if (p_hs) begin
        rd_q <= rd_q + 1'b1;
        x_q  <= eol ? '0 : x_q + 1'b1;
        if (eol) y_q <= y_q == YW'(V_VISIBLE - 1) ? '0 : y_q + 1'b1;
      end
      if (r_push && bus.axi_rresp != 2'b00) err_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (r_push) mem_q[wr_q[PW-1:0]] <= bus.axi_rdata[PIXEL_BITS-1:0];
  end
endmodule

// File: tb/tb_fb_pixel_reader.sv
// tb_fb_pixel_reader: directed scenarios against a small AXI read slave and pixel sink model
module tb_fb_pixel_reader;
  localparam int H = 4, V = 2, PB = 12, AW = 20, DW = 16, MAX = 4;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  int   pass_n = 0, total_n = 0;
  int   pr_mode = 0, err_addr = -1, ar_count = 0;
  bit   rnd = 1'b0, r_stall = 1'b0, flush = 1'b0;
  logic [PB+1:0] got[$];
  logic [AW-1:0] pend[$];
  always #5 clk = ~clk;
  fb_pixel_reader_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .PIXEL_BITS(PB)) bus();
  fb_pixel_reader #(.H_VISIBLE(H), .V_VISIBLE(V), .PIXEL_BITS(PB), .AXI_ADDR_WIDTH(AW),
                    .AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX))
    dut (.clk(clk), .reset(reset), .enable(enable), .bus(bus));
  // slave: records handshakes at the negedge, updates its outputs just after the posedge
  initial begin
    bit ar_fire, r_fire;
    logic [AW-1:0] a;
    bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0;
    bus.axi_rresp = 2'b00;  bus.pixel_ready = 1'b0;
    forever begin
      @(negedge clk);
      ar_fire = bus.axi_arvalid && bus.axi_arready;
      r_fire  = bus.axi_rvalid && bus.axi_rready;
      if (ar_fire) begin pend.push_back(bus.axi_araddr); ar_count++; end
      if (bus.pixel_valid && bus.pixel_ready) got.push_back({bus.pixel_sof, bus.pixel_eol, bus.pixel_data});
      @(posedge clk); #1;
      if (r_fire) bus.axi_rvalid = 1'b0;
      if (flush) begin pend.delete(); bus.axi_rvalid = 1'b0; end
      else if (!bus.axi_rvalid && pend.size() > 0 && !r_stall && (!rnd || $urandom_range(0, 2) == 0)) begin
        a = pend.pop_front();
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = DW'(a);
        bus.axi_rresp  = (int'(a) == err_addr) ? 2'd2 : 2'd0;
      end
      bus.axi_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pixel_ready = pr_mode == 0 ? 1'b1 : pr_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  function automatic logic [PB+1:0] exp_px(input int i);
    int k = i % (H * V);
    return {k == 0, k % H == H - 1, PB'(k)};
  endfunction
  task automatic wait_px(input int b, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = got.size() - b >= n;
    end
  endtask
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.axi_rready && !bus.pixel_valid;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    total_n++; if (bus.axi_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", bus.axi_arvalid); else pass_n++;
    total_n++; if (bus.axi_araddr !== '0) $display("FAIL rst_araddr: got %h want 0", bus.axi_araddr); else pass_n++;
    total_n++; if (bus.axi_rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", bus.axi_rready); else pass_n++;
    total_n++; if (bus.pixel_valid !== 1'b0) $display("FAIL rst_pvalid: got %b want 0", bus.pixel_valid); else pass_n++;
    total_n++; if (bus.pixel_data !== '0) $display("FAIL rst_pdata: got %h want 0", bus.pixel_data); else pass_n++;
    total_n++; if ({bus.pixel_sof, bus.pixel_eol} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {bus.pixel_sof, bus.pixel_eol}); else pass_n++;
    total_n++; if (bus.read_error !== 1'b0) $display("FAIL rst_rderr: got %b want 0", bus.read_error); else pass_n++;
    reset = 1'b0;
  endtask
  task automatic test_basic;
    int b = got.size();
    bit ok;
    pr_mode = 0; rnd = 1'b0; enable = 1'b1;
    wait_px(b, 10, ok);
    total_n++; if (!ok) $display("FAIL basic_timeout: got %0d pixels want 10", got.size() - b); else pass_n++;
    for (int i = 0; i < 10 && ok; i++) begin
      total_n++; if (got[b+i] !== exp_px(i)) $display("FAIL basic_px%0d: got %h want %h", i, got[b+i], exp_px(i)); else pass_n++;
    end
    enable = 1'b0;
    wait_idle(ok);
    total_n++; if (!ok) $display("FAIL basic_idle: got busy want idle"); else pass_n++;
    total_n++; if (bus.axi_arvalid !== 1'b0) $display("FAIL basic_arvalid: got %b want 0", bus.axi_arvalid); else pass_n++;
  endtask
  task automatic test_backpressure;
    int b = got.size(), a0 = ar_count, n;
    bit ok;
    pr_mode = 1;
    @(negedge clk); enable = 1'b1;
    repeat (30) @(negedge clk);
    total_n++; if (ar_count - a0 !== 4) $display("FAIL bp_ar_count: got %0d want 4", ar_count - a0); else pass_n++;
    total_n++; if (bus.axi_arvalid !== 1'b0) $display("FAIL bp_arvalid: got %b want 0", bus.axi_arvalid); else pass_n++;
    total_n++; if ({bus.pixel_valid, bus.pixel_sof, bus.pixel_data} !== {2'b11, PB'(0)}) $display("FAIL bp_head: got %h want %h", {bus.pixel_valid, bus.pixel_sof, bus.pixel_data}, {2'b11, PB'(0)}); else pass_n++;
    repeat (7) @(negedge clk);
    total_n++; if (bus.pixel_data !== '0) $display("FAIL bp_hold: got %h want 0", bus.pixel_data); else pass_n++;
    total_n++; if (ar_count - a0 !== 4) $display("FAIL bp_ar_hold: got %0d want 4", ar_count - a0); else pass_n++;
    enable = 1'b0; pr_mode = 0;
    wait_idle(ok);
    n = got.size() - b;
    total_n++; if (!ok || n != 8) $display("FAIL bp_count: got %0d pixels want 8", n); else pass_n++;
    for (int i = 0; i < n; i++) begin
      total_n++; if (got[b+i] !== exp_px(i)) $display("FAIL bp_px%0d: got %h want %h", i, got[b+i], exp_px(i)); else pass_n++;
    end
  endtask
  task automatic test_random;
    int b = got.size(), n;
    bit ok;
    rnd = 1'b1; pr_mode = 2; enable = 1'b1;
    wait_px(b, 24, ok);
    enable = 1'b0;
    wait_idle(ok);
    n = got.size() - b;
    total_n++; if (!ok || n < 24 || n % 8 != 0) $display("FAIL rnd_count: got %0d pixels want whole frames >= 24", n); else pass_n++;
    for (int i = 0; i < n; i++) begin
      total_n++; if (got[b+i] !== exp_px(i)) $display("FAIL rnd_px%0d: got %h want %h", i, got[b+i], exp_px(i)); else pass_n++;
    end
    rnd = 1'b0; pr_mode = 0;
  endtask
  task automatic test_enable_drop;
    int b = got.size(), n;
    bit ok;
    enable = 1'b1;
    wait_px(b, 3, ok);
    enable = 1'b0;
    wait_idle(ok);
    n = got.size() - b;
    total_n++; if (!ok || n != 8) $display("FAIL drop_count: got %0d pixels want 8", n); else pass_n++;
    for (int i = 0; i < n; i++) begin
      total_n++; if (got[b+i] !== exp_px(i)) $display("FAIL drop_px%0d: got %h want %h", i, got[b+i], exp_px(i)); else pass_n++;
    end
    repeat (3) @(negedge clk);
    total_n++; if ({bus.axi_arvalid, bus.axi_rready} !== 2'b00) $display("FAIL drop_idle: got %b want 00", {bus.axi_arvalid, bus.axi_rready}); else pass_n++;
  endtask
  task automatic test_error;
    int b = got.size();
    bit ok, seen = 1'b0;
    total_n++; if (bus.read_error !== 1'b0) $display("FAIL err_pre: got %b want 0", bus.read_error); else pass_n++;
    err_addr = 5; enable = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus.axi_rvalid && bus.axi_rready && bus.axi_rresp != 2'b00;
    end
    total_n++; if (!seen) $display("FAIL err_beat: got no error beat want one"); else pass_n++;
    total_n++; if (bus.read_error !== 1'b0) $display("FAIL err_same_cycle: got %b want 0", bus.read_error); else pass_n++;
    @(negedge clk);
    total_n++; if (bus.read_error !== 1'b1) $display("FAIL err_next_cycle: got %b want 1", bus.read_error); else pass_n++;
    enable = 1'b0;
    wait_idle(ok);
    total_n++; if (bus.read_error !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.read_error); else pass_n++;
    total_n++; if (!ok || got.size() - b != 8) $display("FAIL err_count: got %0d pixels want 8", got.size() - b); else pass_n++;
    total_n++; if (got.size() - b < 6 || got[b+5] !== exp_px(5)) $display("FAIL err_px5: got %h want %h", got.size() - b < 6 ? '0 : got[b+5], exp_px(5)); else pass_n++;
    err_addr = -1;
  endtask
  task automatic test_reset_mid;
    int a0 = ar_count, b, n;
    bit ok;
    r_stall = 1'b1; pr_mode = 0; enable = 1'b1;
    for (int i = 0; i < 100 && ar_count - a0 < 3; i++) @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    total_n++; if ({bus.axi_arvalid, bus.axi_araddr, bus.axi_rready} !== '0) $display("FAIL rmid_axi: got %h want 0", {bus.axi_arvalid, bus.axi_araddr, bus.axi_rready}); else pass_n++;
    total_n++; if ({bus.pixel_valid, bus.pixel_sof, bus.pixel_eol, bus.pixel_data} !== '0) $display("FAIL rmid_pix: got %h want 0", {bus.pixel_valid, bus.pixel_sof, bus.pixel_eol, bus.pixel_data}); else pass_n++;
    total_n++; if (bus.read_error !== 1'b0) $display("FAIL rmid_rderr: got %b want 0", bus.read_error); else pass_n++;
    reset = 1'b0; r_stall = 1'b0;
    repeat (5) @(negedge clk);
    total_n++; if ({bus.pixel_valid, bus.axi_rready} !== 2'b00) $display("FAIL rmid_late: got %b want 00", {bus.pixel_valid, bus.axi_rready}); else pass_n++;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    b = got.size();
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.axi_arvalid;
    end
    total_n++; if (!ok || bus.axi_araddr !== '0) $display("FAIL rmid_addr0: got %h want 0", bus.axi_araddr); else pass_n++;
    enable = 1'b0;
    wait_idle(ok);
    n = got.size() - b;
    total_n++; if (!ok || n != 8) $display("FAIL rmid_count: got %0d pixels want 8", n); else pass_n++;
    for (int i = 0; i < n; i++) begin
      total_n++; if (got[b+i] !== exp_px(i)) $display("FAIL rmid_px%0d: got %h want %h", i, got[b+i], exp_px(i)); else pass_n++;
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_enable_drop();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/fb_pixel_reader.md
FB_PIXEL_READER -- requirements
Module: fb_pixel_reader

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, pixels per line.
REQ-002 SHALL have parameter V_VISIBLE, default 480, lines per frame.
REQ-003 SHALL have parameter PIXEL_BITS, default 12, output pixel width.
REQ-004 SHALL have parameter AXI_ADDR_WIDTH, default 20, framebuffer address width.
REQ-005 SHALL have parameter AXI_DATA_WIDTH, default 16, read data width, with AXI_DATA_WIDTH >= PIXEL_BITS.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 4, read credit limit, power of two.
REQ-007 SHALL have one clock and synchronous active-high reset: clk input 1, rising-edge clock for all logic; reset input 1, synchronous, active-high.
REQ-008 SHALL have port enable input 1, start or continue frame fetching.
REQ-009 SHALL have ports axi_araddr output AXI_ADDR_WIDTH, read address; axi_arvalid output 1; axi_arready input 1.
REQ-010 SHALL have ports axi_rdata input AXI_DATA_WIDTH; axi_rresp input 2; axi_rvalid input 1; axi_rready output 1.
REQ-011 SHALL have ports pixel_data output PIXEL_BITS; pixel_valid output 1; pixel_ready input 1; pixel_sof output 1, first pixel of frame; pixel_eol output 1, last pixel of line.
REQ-012 SHALL have port read_error output 1, sticky, set on any rresp != 0.

Function
REQ-013 SHALL fetch pixels in raster order, address = y*H_VISIBLE + x, computed by incrementing an address counter, no multiplier.
REQ-014 SHALL use FSM states IDLE, FETCH, DRAIN.
REQ-015 IDLE -> FETCH when enable=1; address, x, y counters cleared to 0 on entry.
REQ-016 FETCH -> DRAIN after the handshake (arvalid&arready) of address H_VISIBLE*V_VISIBLE-1.
REQ-017 DRAIN -> FETCH (new frame, counters cleared) when all outstanding data delivered and enable=1; DRAIN -> IDLE when delivered and enable=0.
REQ-018 enable=0 during FETCH SHALL not abort the frame; the frame completes.
REQ-019 SHALL assert axi_arvalid in FETCH only when issued-but-undelivered count < MAX_OUTSTANDING; once asserted, arvalid and araddr SHALL hold until arready.
REQ-020 SHALL contain a MAX_OUTSTANDING-entry FIFO for read data; credits reserve FIFO space, so axi_rready SHALL be held 1 and never drop data.
REQ-021 Credit count SHALL increment on AR handshake, decrement on pixel handshake (valid&ready); simultaneous events leave it unchanged.
REQ-022 pixel_data SHALL be axi_rdata[PIXEL_BITS-1:0] of the corresponding beat, in order; upper bits discarded.
REQ-023 pixel_valid SHALL assert the cycle after the first R beat enters an empty FIFO (1-cycle latency); data/flags SHALL hold while valid&!ready.
REQ-024 pixel_sof SHALL be 1 with pixel (0,0); pixel_eol with x=H_VISIBLE-1, tracked by an output-side x/y counter, wrap x at H_VISIBLE, y at V_VISIBLE.
REQ-025 FIFO full and empty SHALL be distinguished with an extra pointer bit; simultaneous push and pop at full or empty SHALL be correct.
REQ-026 read_error SHALL set on rvalid&rresp!=0 and clear only by reset; the erroneous beat is still delivered.

Reset
REQ-027 On reset: state IDLE, counters and FIFO pointers 0, axi_arvalid=0, axi_araddr=0, axi_rready=0, pixel_valid=0, pixel_data=0, pixel_sof=0, pixel_eol=0, read_error=0.
REQ-028 Reset mid-frame SHALL discard FIFO contents and credits; R beats arriving after reset SHALL be ignored; rready returns to 1 in FETCH.

Verification
REQ-029 H=4, V=2, enable=1, arready=1, rdata=address, pixel_ready=1 -> pixels 0..7 in order, sof on 0, eol on 3 and 7, then new frame at 0.
REQ-030 pixel_ready=0 throughout -> exactly 4 AR handshakes, arvalid then held 0, pixel_data 0 held stable.
REQ-031 Random arready/rvalid delay and pixel_ready backpressure over 3 frames -> sequence matches address order, no loss, no duplicate.
REQ-032 enable dropped at pixel 2 of H=4,V=2 -> all 8 pixels delivered, then IDLE, arvalid=0.
REQ-033 rresp=2 on beat 5 -> read_error=1 from next cycle, stays 1, pixel 5 still delivered.
REQ-034 reset asserted with 3 reads outstanding -> all outputs at reset values next cycle, late rvalid ignored, next frame starts at address 0.
